sc_backg_shift_ctrl: RTL and testbench
======================================

// Module: sc_backg_shift_ctrl
// PURPOSE
//  Control FSM that drives one background-type row register: issues clear, per-level load,
//  timed rotate strobes and the final-register load. Sits between game logic (start, level-up,
//  game-over, pause) and the row register; one instance per lane, direction set per lane.
// PARAMETERS
//  TICK_WIDTH     24          width of the shift-period prescaler counter
//  PERIOD_LEVEL1  24'd5000000 clocks between rotate strobes at level 0 (>=2)
//  PERIOD_LEVEL2  24'd4000000 same, level 1 (>=2)
//  PERIOD_LEVEL3  24'd3000000 same, level 2 (>=2)
//  PERIOD_LEVEL4  24'd2000000 same, level 3 (>=2)
//  SHIFT_DIR      2'b01       shift code issued on each strobe (2'b01 rotate left, 2'b10 right)
// PORTS
//  SC_BACKGCTRL_CLOCK_50                   in   1  system clock
//  SC_BACKGCTRL_RESET_InHigh               in   1  async reset, active high
//  SC_BACKGCTRL_start_InLow                in   1  start/restart request, sampled in IDLE/DONE only
//  SC_BACKGCTRL_pause_InLow                in   1  level; 0 freezes prescaler
//  SC_BACKGCTRL_levelup_InLow              in   1  1-cycle pulse: lane level complete
//  SC_BACKGCTRL_gameover_InLow             in   1  1-cycle pulse: frog lost
//  SC_BACKGCTRL_clear_OutLow               out  1  register clear strobe
//  SC_BACKGCTRL_load_OutLow                out  1  register level-load strobe
//  SC_BACKGCTRL_LoadFinalRegister_OutLow   out  1  final-pattern load strobe
//  SC_BACKGCTRL_shiftselection_Out         out  2  00 hold, SHIFT_DIR during shift strobe
//  SC_BACKGCTRL_transitioncounter_OutBUS   out  2  current level index 0..3
//  SC_BACKGCTRL_won_OutHigh                out  1  1 in DONE after winning level 3
// BEHAVIOUR
//  - One clock; reset asynchronous, active high. Reset (any time, mid-operation included):
//    state IDLE, prescaler 0, level 0, won 0; all _OutLow = 1, shiftselection = 00, at once.
//  - Moore outputs decoded from registered state; every strobe lasts exactly one cycle.
//  - IDLE: start_InLow=0 -> CLEAR. CLEAR: clear_OutLow=0, level<=0 -> LOAD.
//  - LOAD: load_OutLow=0, transitioncounter stable = new level; prescaler<=0 -> RUN.
//    Latency: start low at edge k -> clear low cycle k+1, load low k+2, RUN from k+3.
//  - RUN: priority gameover > levelup > tick. gameover=0 -> DONE (won=0).
//    levelup=0 -> LEVELUP. Else if pause=1: prescaler++; at PERIOD(level)-1 prescaler<=0 -> SHIFT.
//    pause=0 holds prescaler; gameover/levelup still honoured while paused.
//  - SHIFT: shiftselection=SHIFT_DIR one cycle -> RUN (SHIFT cycle counts as prescaler count 0,
//    so strobes are exactly PERIOD(level) clocks apart while unpaused).
//  - LEVELUP: level<3: level++ -> LOAD. level==3: -> FINAL.
//  - FINAL: LoadFinalRegister_OutLow=0 one cycle, won<=1 -> DONE.
//  - DONE: all strobes inactive, level held; start_InLow=0 -> CLEAR (won<=0).
//  - levelup/gameover/start outside their listed states are ignored (no latching).
//  - Prescaler never wraps: compare is ==PERIOD-1 and reset on hit or leaving RUN.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE, CLEAR, LOAD, RUN, SHIFT, LEVELUP,
//    FINAL, DONE; 3 bits), shift codes SHIFT_HOLD=2'b00 / SHIFT_LEFT=2'b01 /
//    SHIFT_RIGHT=2'b10, and LEVEL_LAST=2'd3; same constants used by the row register.
//  - Sub-module sc_backg_tick_prescaler: counter with enable, sync clear, terminal-count
//    input (muxed from PERIOD_LEVELx by level) and 1-cycle tick output.
//  - Top: state register, next-state logic, level register, output decode.
// TESTING (PERIOD_LEVEL1..4 = 4,3,2,2; SHIFT_DIR=2'b01)
//  - Reset then start low 1 cycle at edge 10 -> clear low cycle 11, load low 12, tc=00, no strobe before.
//  - RUN level 0, pause=1 for 20 cycles -> shiftselection=01 every 4th cycle, 00 otherwise.
//  - Pause low 6 cycles mid-period -> shift strobe delayed exactly 6 cycles; levelup during pause -> LOAD tc=01.
//  - Four levelup pulses -> loads with tc 01,10,11 then LoadFinalRegister low 1 cycle, won=1, DONE.
//  - levelup and gameover same cycle -> DONE, won=0, no load strobe; start again -> clear, tc=00.
//  - Assert reset during SHIFT and during LOAD -> outputs inactive same cycle, IDLE, tc=00.

Source files
------------

// File: rtl/sc_backg_shift_ctrl_pkg.sv
// Shared constants for the background-type lane controller and its row register.
package sc_backg_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    SHIFT   = 3'd4,
    LEVELUP = 3'd5,
    FINAL   = 3'd6,
    DONE    = 3'd7
  } ctrlStateT;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  localparam logic [1:0] LEVEL_LAST = 2'd3;

endpackage

// File: rtl/sc_backg_tick_prescaler.sv
// Shift-period prescaler: counts enabled clocks and emits a one-cycle tick on the
// terminal count, restarting from zero on the tick or on a synchronous clear.
module sc_backg_tick_prescaler #(
  parameter int TICK_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [TICK_WIDTH-1:0] terminalCount,
  output logic                  tick
);

  logic [TICK_WIDTH-1:0] count;

  assign tick = enable && !clear && (count == terminalCount);

  // Count while enabled; the compare-and-restart means the counter never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TICK_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_backg_shift_ctrl.sv
// Lane controller: sequences clear, per-level load, timed rotate strobes and the
// final-pattern load for one background-type row register.
module sc_backg_shift_ctrl
  import sc_backg_shift_ctrl_pkg::*;
#(
  parameter int                    TICK_WIDTH    = 24,
  parameter logic [TICK_WIDTH-1:0] PERIOD_LEVEL1 = 24'd5000000,
  parameter logic [TICK_WIDTH-1:0] PERIOD_LEVEL2 = 24'd4000000,
  parameter logic [TICK_WIDTH-1:0] PERIOD_LEVEL3 = 24'd3000000,
  parameter logic [TICK_WIDTH-1:0] PERIOD_LEVEL4 = 24'd2000000,
  parameter logic [1:0]            SHIFT_DIR     = 2'b01
) (
  input  logic       SC_BACKGCTRL_CLOCK_50,
  input  logic       SC_BACKGCTRL_RESET_InHigh,
  input  logic       SC_BACKGCTRL_start_InLow,
  input  logic       SC_BACKGCTRL_pause_InLow,
  input  logic       SC_BACKGCTRL_levelup_InLow,
  input  logic       SC_BACKGCTRL_gameover_InLow,
  output logic       SC_BACKGCTRL_clear_OutLow,
  output logic       SC_BACKGCTRL_load_OutLow,
  output logic       SC_BACKGCTRL_LoadFinalRegister_OutLow,
  output logic [1:0] SC_BACKGCTRL_shiftselection_Out,
  output logic [1:0] SC_BACKGCTRL_transitioncounter_OutBUS,
  output logic       SC_BACKGCTRL_won_OutHigh
);

  ctrlStateT             state;
  logic [1:0]            level;
  logic [TICK_WIDTH-1:0] terminalCount;
  logic                  tickEnable;
  logic                  tickClear;
  logic                  tick;

  // Terminal count for the current level; the prescaler counts 0..PERIOD-1.
  always_comb begin
    terminalCount = PERIOD_LEVEL1 - TICK_WIDTH'(1);
    case (level)
      2'd0:    terminalCount = PERIOD_LEVEL1 - TICK_WIDTH'(1);
      2'd1:    terminalCount = PERIOD_LEVEL2 - TICK_WIDTH'(1);
      2'd2:    terminalCount = PERIOD_LEVEL3 - TICK_WIDTH'(1);
      default: terminalCount = PERIOD_LEVEL4 - TICK_WIDTH'(1);
    endcase
  end

  // The SHIFT cycle advances the prescaler too, so strobes sit exactly one period apart.
  assign tickEnable = SC_BACKGCTRL_pause_InLow &&
                      ((state == RUN && SC_BACKGCTRL_gameover_InLow && SC_BACKGCTRL_levelup_InLow) ||
                       state == SHIFT);
  assign tickClear  = !(state == RUN || state == SHIFT);

  sc_backg_tick_prescaler #(
    .TICK_WIDTH(TICK_WIDTH)
  ) uPrescaler (
    .clock        (SC_BACKGCTRL_CLOCK_50),
    .reset        (SC_BACKGCTRL_RESET_InHigh),
    .enable       (tickEnable),
    .clear        (tickClear),
    .terminalCount(terminalCount),
    .tick         (tick)
  );

  // Sequencer: state, level and registered strobes that always reflect the state being entered.
  always_ff @(posedge SC_BACKGCTRL_CLOCK_50 or posedge SC_BACKGCTRL_RESET_InHigh) begin
    if (SC_BACKGCTRL_RESET_InHigh) begin
      state                                 <= IDLE;
      level                                 <= 2'd0;
      SC_BACKGCTRL_won_OutHigh              <= 1'b0;
      SC_BACKGCTRL_clear_OutLow             <= 1'b1;
      SC_BACKGCTRL_load_OutLow              <= 1'b1;
      SC_BACKGCTRL_LoadFinalRegister_OutLow <= 1'b1;
      SC_BACKGCTRL_shiftselection_Out       <= SHIFT_HOLD;
    end else begin
      SC_BACKGCTRL_clear_OutLow             <= 1'b1;
      SC_BACKGCTRL_load_OutLow              <= 1'b1;
      SC_BACKGCTRL_LoadFinalRegister_OutLow <= 1'b1;
      SC_BACKGCTRL_shiftselection_Out       <= SHIFT_HOLD;
      case (state)
        IDLE: begin
          if (!SC_BACKGCTRL_start_InLow) begin
            state                     <= CLEAR;
            level                     <= 2'd0;
            SC_BACKGCTRL_clear_OutLow <= 1'b0;
          end
        end
        CLEAR: begin
          state                    <= LOAD;
          level                    <= 2'd0;
          SC_BACKGCTRL_load_OutLow <= 1'b0;
        end
        LOAD: begin
          state <= RUN;
        end
        RUN: begin
          if (!SC_BACKGCTRL_gameover_InLow) begin
            state                    <= DONE;
            SC_BACKGCTRL_won_OutHigh <= 1'b0;
          end else if (!SC_BACKGCTRL_levelup_InLow) begin
            state <= LEVELUP;
          end else if (tick) begin
            state                           <= SHIFT;
            SC_BACKGCTRL_shiftselection_Out <= SHIFT_DIR;
          end
        end
        SHIFT: begin
          state <= RUN;
        end
        LEVELUP: begin
          if (level < LEVEL_LAST) begin
            state                    <= LOAD;
            level                    <= level + 2'd1;
            SC_BACKGCTRL_load_OutLow <= 1'b0;
          end else begin
            state                                 <= FINAL;
            SC_BACKGCTRL_LoadFinalRegister_OutLow <= 1'b0;
          end
        end
        FINAL: begin
          state                    <= DONE;
          SC_BACKGCTRL_won_OutHigh <= 1'b1;
        end
        DONE: begin
          if (!SC_BACKGCTRL_start_InLow) begin
            state                     <= CLEAR;
            level                     <= 2'd0;
            SC_BACKGCTRL_won_OutHigh  <= 1'b0;
            SC_BACKGCTRL_clear_OutLow <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign SC_BACKGCTRL_transitioncounter_OutBUS = level;

endmodule

// File: tb/tb_sc_backg_shift_ctrl.sv
// Directed bench for the lane controller with short periods (4,3,2,2) and left rotation.
module tb_sc_backg_shift_ctrl;

  logic       clk;
  logic       rst;
  logic       startN;
  logic       pauseN;
  logic       levelupN;
  logic       gameoverN;
  logic       clearN;
  logic       loadN;
  logic       finalN;
  logic [1:0] shiftSel;
  logic [1:0] tc;
  logic       won;
  logic [7:0] obsVec;
  logic [7:0] e;
  int         errors;
  int         checks;

  sc_backg_shift_ctrl #(
    .TICK_WIDTH   (24),
    .PERIOD_LEVEL1(24'd4),
    .PERIOD_LEVEL2(24'd3),
    .PERIOD_LEVEL3(24'd2),
    .PERIOD_LEVEL4(24'd2),
    .SHIFT_DIR    (2'b01)
  ) dut (
    .SC_BACKGCTRL_CLOCK_50                (clk),
    .SC_BACKGCTRL_RESET_InHigh            (rst),
    .SC_BACKGCTRL_start_InLow             (startN),
    .SC_BACKGCTRL_pause_InLow             (pauseN),
    .SC_BACKGCTRL_levelup_InLow           (levelupN),
    .SC_BACKGCTRL_gameover_InLow          (gameoverN),
    .SC_BACKGCTRL_clear_OutLow            (clearN),
    .SC_BACKGCTRL_load_OutLow             (loadN),
    .SC_BACKGCTRL_LoadFinalRegister_OutLow(finalN),
    .SC_BACKGCTRL_shiftselection_Out      (shiftSel),
    .SC_BACKGCTRL_transitioncounter_OutBUS(tc),
    .SC_BACKGCTRL_won_OutHigh             (won)
  );

  assign obsVec = {clearN, loadN, finalN, shiftSel, tc, won};

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs an expected output set in the same order as obsVec: clear, load, final, shift, tc, won.
  function automatic logic [7:0] expVec(input logic clr, input logic ld, input logic fin,
                                        input logic [1:0] sh, input logic [1:0] lvl, input logic w);
    return {clr, ld, fin, sh, lvl, w};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; startN = 1'b1; pauseN = 1'b1; levelupN = 1'b1; gameoverN = 1'b1;
    step();
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL reset_state: got %b want %b", obsVec, e); end
    startN = 1'b0;
    step();
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL start_during_reset: got %b want %b", obsVec, e); end
    startN = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_start();
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL idle_no_strobe cycle %0d: got %b want %b", i, obsVec, e); end
    end
    startN = 1'b0;
    step();
    startN = 1'b1;
    e = expVec(0, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL start_clear: got %b want %b", obsVec, e); end
    step();
    e = expVec(1, 0, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL start_load: got %b want %b", obsVec, e); end
    step();
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL start_run: got %b want %b", obsVec, e); end
  endtask

  task automatic test_run_shift();
    for (int s = 1; s <= 20; s++) begin
      step();
      e = expVec(1, 1, 1, (s % 4 == 0) ? 2'b01 : 2'b00, 2'd0, 0);
      checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL run_shift s=%0d: got %b want %b", s, obsVec, e); end
    end
  endtask

  task automatic test_pause();
    for (int s = 21; s <= 31; s++) begin
      if (s == 23) pauseN = 1'b0;
      if (s == 29) pauseN = 1'b1;
      step();
      e = expVec(1, 1, 1, (s == 30) ? 2'b01 : 2'b00, 2'd0, 0);
      checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL pause_delay s=%0d: got %b want %b", s, obsVec, e); end
    end
    pauseN = 1'b0;
    levelupN = 1'b0;
    step();
    levelupN = 1'b1;
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL paused_levelup_state: got %b want %b", obsVec, e); end
    step();
    e = expVec(1, 0, 1, 2'b00, 2'd1, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL paused_levelup_load: got %b want %b", obsVec, e); end
    pauseN = 1'b1;
  endtask

  task automatic test_levelups();
    step();
    e = expVec(1, 1, 1, 2'b00, 2'd1, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL level1_run: got %b want %b", obsVec, e); end
    for (int lvl = 2; lvl <= 3; lvl++) begin
      levelupN = 1'b0;
      step();
      levelupN = 1'b1;
      e = expVec(1, 1, 1, 2'b00, 2'(lvl - 1), 0);
      checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL levelup_state lvl=%0d: got %b want %b", lvl, obsVec, e); end
      step();
      e = expVec(1, 0, 1, 2'b00, 2'(lvl), 0);
      checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL levelup_load lvl=%0d: got %b want %b", lvl, obsVec, e); end
      step();
      e = expVec(1, 1, 1, 2'b00, 2'(lvl), 0);
      checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL levelup_run lvl=%0d: got %b want %b", lvl, obsVec, e); end
    end
    levelupN = 1'b0;
    step();
    levelupN = 1'b1;
    e = expVec(1, 1, 1, 2'b00, 2'd3, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL last_levelup_state: got %b want %b", obsVec, e); end
    step();
    e = expVec(1, 1, 0, 2'b00, 2'd3, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL final_load: got %b want %b", obsVec, e); end
    step();
    e = expVec(1, 1, 1, 2'b00, 2'd3, 1);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL done_won: got %b want %b", obsVec, e); end
    levelupN = 1'b0;
    gameoverN = 1'b0;
    step();
    levelupN = 1'b1;
    gameoverN = 1'b1;
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL done_ignores_pulses: got %b want %b", obsVec, e); end
    step();
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL done_hold: got %b want %b", obsVec, e); end
  endtask

  task automatic test_back_to_back();
    startN = 1'b0;
    step();
    startN = 1'b1;
    e = expVec(0, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL restart_clear: got %b want %b", obsVec, e); end
    step();
    e = expVec(1, 0, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL restart_load: got %b want %b", obsVec, e); end
    step();
    levelupN = 1'b0;
    gameoverN = 1'b0;
    step();
    levelupN = 1'b1;
    gameoverN = 1'b1;
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL collision_done: got %b want %b", obsVec, e); end
    step();
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL collision_no_load: got %b want %b", obsVec, e); end
    startN = 1'b0;
    step();
    startN = 1'b1;
    e = expVec(0, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL after_gameover_clear: got %b want %b", obsVec, e); end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    // RUN at level 0 with prescaler at 0; the fourth edge lands in SHIFT.
    startN = 1'b0;
    step();
    startN = 1'b1;
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL start_ignored_in_run: got %b want %b", obsVec, e); end
    step();
    step();
    step();
    e = expVec(1, 1, 1, 2'b01, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL pre_reset_shift: got %b want %b", obsVec, e); end
    #1 rst = 1'b1;
    #1;
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL reset_in_shift: got %b want %b", obsVec, e); end
    rst = 1'b0;
    step();
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL idle_after_shift_reset: got %b want %b", obsVec, e); end
    startN = 1'b0;
    step();
    startN = 1'b1;
    step();
    step();
    levelupN = 1'b0;
    step();
    levelupN = 1'b1;
    step();
    e = expVec(1, 0, 1, 2'b00, 2'd1, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL pre_reset_load: got %b want %b", obsVec, e); end
    #1 rst = 1'b1;
    #1;
    e = expVec(1, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL reset_in_load: got %b want %b", obsVec, e); end
    rst = 1'b0;
    step();
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL idle_after_load_reset: got %b want %b", obsVec, e); end
    startN = 1'b0;
    step();
    startN = 1'b1;
    e = expVec(0, 1, 1, 2'b00, 2'd0, 0);
    checks++; if (obsVec !== e) begin errors++; $display("[TB] FAIL start_after_reset: got %b want %b", obsVec, e); end
  endtask

  // Guards against a stalled simulation.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence.
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_start();
    test_run_shift();
    test_pause();
    test_levelups();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
